// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - next fetch address with MIPS branch-delay-slot sequencing
module next_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h80020000,
  parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] currentpc,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  input  logic        exception,
  output logic [31:0] nextpc,
  output logic        in_delay_slot,
  output logic        addr_error,
  output logic        slot_violation
);

  typedef enum logic {SEQ = 1'b0, DSLOT = 1'b1} state_t;

  state_t      state, state_d;
  logic [31:0] pend_target, pend_target_d;
  logic        addr_error_d, slot_violation_d;
  logic        redirect;
  logic [31:0] sel_target;
  logic [31:0] seq_pc;

  assign redirect      = jump_valid | (branch_valid & branch_taken);
  assign sel_target    = jump_valid ? jump_target : branch_target;
  assign seq_pc        = currentpc + 32'd4;
  assign in_delay_slot = (state == DSLOT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= SEQ;
      pend_target    <= '0;
      addr_error     <= 1'b0;
      slot_violation <= 1'b0;
    end else begin
      state          <= state_d;
      pend_target    <= pend_target_d;
      addr_error     <= addr_error_d;
      slot_violation <= slot_violation_d;
    end
  end

  always_comb begin
    state_d          = state;
    pend_target_d    = pend_target;
    addr_error_d     = 1'b0;
    slot_violation_d = slot_violation;
    nextpc           = seq_pc;
    if (reset) begin
      nextpc = RESET_PC;
    end else if (exception) begin
      nextpc        = EXC_VECTOR;
      state_d       = SEQ;
      pend_target_d = '0;
    end else if (stall) begin
      // Redirects seen during a stall are dropped; decode re-presents them.
      nextpc = currentpc;
    end else if (state == SEQ) begin
      nextpc = seq_pc;
      if (redirect) begin
        pend_target_d = sel_target & ~32'h3;
        state_d       = DSLOT;
        addr_error_d  = |sel_target[1:0];
      end
    end else begin
      nextpc  = pend_target;
      state_d = SEQ;
      if (redirect) begin
        slot_violation_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - scoreboard bench for next_pc_unit
module tb_next_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] currentpc;
  logic        stall;
  logic        branch_valid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        exception;
  logic [31:0] nextpc;
  logic        in_delay_slot;
  logic        addr_error;
  logic        slot_violation;

  typedef struct packed {
    logic [31:0] npc;
    logic        ds;
    logic        ae;
    logic        sv;
  } exp_t;

  exp_t q[$];
  logic chk = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  next_pc_unit dut (
    .clock(clock), .reset(reset), .currentpc(currentpc), .stall(stall),
    .branch_valid(branch_valid), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_valid(jump_valid), .jump_target(jump_target), .exception(exception),
    .nextpc(nextpc), .in_delay_slot(in_delay_slot), .addr_error(addr_error),
    .slot_violation(slot_violation)
  );

  always #5 clock = ~clock;

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clock) begin
    if (chk) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL underflow: output present with no expected entry at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        compared++;
        if (nextpc !== e.npc) begin
          mismatched++;
          $display("FAIL nextpc pc=%08h: got %08h want %08h", currentpc, nextpc, e.npc);
        end
        compared++;
        if (in_delay_slot !== e.ds) begin
          mismatched++;
          $display("FAIL in_delay_slot pc=%08h: got %b want %b", currentpc, in_delay_slot, e.ds);
        end
        compared++;
        if (addr_error !== e.ae) begin
          mismatched++;
          $display("FAIL addr_error pc=%08h: got %b want %b", currentpc, addr_error, e.ae);
        end
        compared++;
        if (slot_violation !== e.sv) begin
          mismatched++;
          $display("FAIL slot_violation pc=%08h: got %b want %b", currentpc, slot_violation, e.sv);
        end
      end
    end
  end

  task automatic cyc(input logic rst, input logic [31:0] pc, input logic st,
                     input logic bv, input logic bt, input logic [31:0] btgt,
                     input logic jv, input logic [31:0] jtgt, input logic exc,
                     input logic [31:0] e_npc, input logic e_ds, input logic e_ae,
                     input logic e_sv);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; currentpc = pc; stall = st;
    branch_valid = bv; branch_taken = bt; branch_target = btgt;
    jump_valid = jv; jump_target = jtgt; exception = exc;
    e.npc = e_npc; e.ds = e_ds; e.ae = e_ae; e.sv = e_sv;
    q.push_back(e);
    chk = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; currentpc = '0; stall = 1'b0;
    branch_valid = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump_valid = 1'b0; jump_target = '0; exception = 1'b0;
    @(posedge clock);
    // reset wins over exception and jump inputs
    cyc(1, 32'h80020010, 0, 1, 1, 32'h80020100, 1, 32'h80030000, 1, 32'h80020000, 0, 0, 0);
    cyc(0, 32'h80020000, 0, 0, 0, 0,            0, 0,            0, 32'h80020004, 0, 0, 0);
    // taken branch
    cyc(0, 32'h80020010, 0, 1, 1, 32'h80020100, 0, 0,            0, 32'h80020014, 0, 0, 0);
    cyc(0, 32'h80020014, 0, 0, 0, 0,            0, 0,            0, 32'h80020100, 1, 0, 0);
    cyc(0, 32'h80020100, 0, 0, 0, 0,            0, 0,            0, 32'h80020104, 0, 0, 0);
    // not-taken branch
    cyc(0, 32'h80020020, 0, 1, 0, 32'h80020300, 0, 0,            0, 32'h80020024, 0, 0, 0);
    cyc(0, 32'h80020024, 0, 0, 0, 0,            0, 0,            0, 32'h80020028, 0, 0, 0);
    // jump beats simultaneous taken branch
    cyc(0, 32'h80020028, 0, 1, 1, 32'h80020200, 1, 32'h80030000, 0, 32'h8002002C, 0, 0, 0);
    cyc(0, 32'h8002002C, 0, 0, 0, 0,            0, 0,            0, 32'h80030000, 1, 0, 0);
    // stall inside delay slot
    cyc(0, 32'h80030000, 0, 1, 1, 32'h80030040, 0, 0,            0, 32'h80030004, 0, 0, 0);
    cyc(0, 32'h80030004, 1, 0, 0, 0,            0, 0,            0, 32'h80030004, 1, 0, 0);
    cyc(0, 32'h80030004, 1, 0, 0, 0,            0, 0,            0, 32'h80030004, 1, 0, 0);
    cyc(0, 32'h80030004, 1, 0, 0, 0,            0, 0,            0, 32'h80030004, 1, 0, 0);
    cyc(0, 32'h80030004, 0, 0, 0, 0,            0, 0,            0, 32'h80030040, 1, 0, 0);
    cyc(0, 32'h80030040, 0, 0, 0, 0,            0, 0,            0, 32'h80030044, 0, 0, 0);
    // exception with stall in delay slot drops the pending target
    cyc(0, 32'h80030044, 0, 0, 0, 0,            1, 32'h80040000, 0, 32'h80030048, 0, 0, 0);
    cyc(0, 32'h80030048, 1, 0, 0, 0,            0, 0,            1, 32'h80000180, 1, 0, 0);
    cyc(0, 32'h80000180, 0, 0, 0, 0,            0, 0,            0, 32'h80000184, 0, 0, 0);
    // wrap-around
    cyc(0, 32'hFFFFFFFC, 0, 0, 0, 0,            0, 0,            0, 32'h00000000, 0, 0, 0);
    // misaligned jump target
    cyc(0, 32'h80020000, 0, 0, 0, 0,            1, 32'h80020102, 0, 32'h80020004, 0, 0, 0);
    cyc(0, 32'h80020004, 0, 0, 0, 0,            0, 0,            0, 32'h80020100, 1, 1, 0);
    cyc(0, 32'h80020100, 0, 0, 0, 0,            0, 0,            0, 32'h80020104, 0, 0, 0);
    // redirect inside delay slot is ignored and flagged
    cyc(0, 32'h80020104, 0, 1, 1, 32'h80020200, 0, 0,            0, 32'h80020108, 0, 0, 0);
    cyc(0, 32'h80020108, 0, 0, 0, 0,            1, 32'h80050000, 0, 32'h80020200, 1, 0, 0);
    cyc(0, 32'h80020200, 0, 0, 0, 0,            0, 0,            0, 32'h80020204, 0, 0, 1);
    cyc(0, 32'h80020204, 0, 0, 0, 0,            0, 0,            0, 32'h80020208, 0, 0, 1);
    // reset while in delay slot
    cyc(0, 32'h80020208, 0, 1, 1, 32'h80020400, 0, 0,            0, 32'h8002020C, 0, 0, 1);
    cyc(1, 32'h8002020C, 0, 0, 0, 0,            0, 0,            0, 32'h80020000, 1, 0, 1);
    cyc(0, 32'h80020000, 0, 0, 0, 0,            0, 0,            0, 32'h80020004, 0, 0, 0);
    // redirect during stall in SEQ is dropped
    cyc(0, 32'h80020004, 1, 0, 0, 0,            1, 32'h80060000, 0, 32'h80020004, 0, 0, 0);
    cyc(0, 32'h80020004, 0, 0, 0, 0,            0, 0,            0, 32'h80020008, 0, 0, 0);
    cyc(0, 32'h80020008, 0, 0, 0, 0,            0, 0,            0, 32'h8002000C, 0, 0, 0);
    @(posedge clock);
    #1;
    chk = 1'b0;
    #10;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
